weight_row_writer: RTL and testbench

- Loader for the weight RAM. It accepts a serial stream of fixed-point weight words over a valid/ready handshake.
- It packs NCOLS words into one row, then issues one single-cycle row write per packed row to addresses 0..NROWS-1.
- It sits between the host/DMA weight source and the write port of weightRAM. The LSTM datapath then reads rows back by address.

---
 rtl/weight_row_writer_pkg.sv | 21 ++
 rtl/weight_row_packer.sv | 45 ++++
 rtl/weight_row_writer.sv | 103 ++++++++++
 tb/tb_weight_row_writer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_row_writer_pkg.sv
// Shared sizing and state encoding for the weight RAM loader, its packer and weightRAM.
package weight_row_writer_pkg;

  localparam int BITWIDTH = 18;
  localparam int NCOLS    = 16;
  localparam int NROWS    = 16;
  localparam int ADDR_W   = 4;
  localparam int ROW_W    = NCOLS * BITWIDTH;
  localparam int COL_W    = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wrw_state_e;

  // Column c of a row lives at bits [c*BITWIDTH +: BITWIDTH].
  typedef logic [NCOLS-1:0][BITWIDTH-1:0] row_t;

endpackage

// File: rtl/weight_row_packer.sv
// Packs accepted weight words into one RAM row, column by column.
// Latency: row_next/row_full are combinational on the accepting cycle.
// Backpressure: none internally; the caller qualifies every word with accept.
module weight_row_packer
  import weight_row_writer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                accept,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                row_full,
  output row_t                row_next
);

  row_t             row_q;
  logic [COL_W-1:0] col_cnt;
  logic             last_col;

  assign last_col = (col_cnt == COL_W'(NCOLS - 1));
  assign row_full = accept & last_col;

  // row_next includes the word being accepted, so the caller can capture a
  // complete row on the same edge that takes the final column.
  always_comb begin
    row_next = row_q;
    if (accept) begin
      row_next[col_cnt] = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_cnt <= '0;
      row_q   <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_q   <= '0;
    end else if (accept) begin
      row_q   <= row_next;
      col_cnt <= last_col ? '0 : col_cnt + COL_W'(1);
    end
  end

endmodule

// File: rtl/weight_row_writer.sv
// Streams weight words into packed rows and writes each row to weightRAM.
// Latency: wr_en is high in the cycle after the edge that accepts a row's last word.
// Backpressure: in_ready drops in IDLE, WRITE and DONE; words wait with in_valid held.
module weight_row_writer
  import weight_row_writer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [ROW_W-1:0]    wr_data,
  output logic                busy,
  output logic                done
);

  wrw_state_e        state_q;
  wrw_state_e        state_d;
  logic [ADDR_W-1:0] row_cnt;
  logic              accept;
  logic              load_start;
  logic              row_full;
  logic              last_row;
  row_t              row_next;

  assign accept     = in_valid & in_ready;
  assign load_start = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign last_row   = (row_cnt == ADDR_W'(NROWS - 1));

  weight_row_packer u_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (load_start),
    .accept   (accept),
    .in_data  (in_data),
    .row_full (row_full),
    .row_next (row_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE,
      ST_DONE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (row_full) state_d = ST_WRITE;
      ST_WRITE: state_d = last_row ? ST_DONE : ST_FILL;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and status decode straight from the state register, so
  // in_ready never depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // wr_addr/wr_data are captured only when a row completes, so they hold
  // steady between write strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (load_start) begin
        row_cnt <= '0;
      end else if ((state_q == ST_WRITE) && !last_row) begin
        row_cnt <= row_cnt + ADDR_W'(1);
      end
      if (row_full) begin
        wr_addr <= row_cnt;
        wr_data <= row_next;
      end
    end
  end

endmodule

// File: tb/tb_weight_row_writer.sv
// Directed bench for weight_row_writer with a behavioural weightRAM image.
module tb_weight_row_writer;
  import weight_row_writer_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [BITWIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ROW_W-1:0]    wr_data;
  logic                busy;
  logic                done;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [ROW_W-1:0]  wd_q[$];
  logic [ROW_W-1:0]  ram [NROWS];

  weight_row_writer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // weightRAM stand-in: records every row write seen between edges.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      ram[wr_addr] = wr_data;
    end
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] exp_row(input int base, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < NCOLS; c++) begin
      v[c*BITWIDTH +: BITWIDTH] = BITWIDTH'(base + r*NCOLS + c);
    end
    return v;
  endfunction

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk_b("restart_done_cleared", done, 1'b0);
    chk_b("restart_busy", busy, 1'b1);
    chk_b("restart_in_ready", in_ready, 1'b1);
  endtask

  // Streams words base+w; a full load also checks timing and every row write.
  task automatic load(input int base, input bit bubbles, input int start_at, input int nwords);
    int               w = 0;
    int               k = 0;
    int               idle = 0;
    int unsigned      first_cyc = 0;
    bit               spulsed = 1'b0;
    logic [ROW_W-1:0] rw;
    wa_q.delete();
    wd_q.delete();
    while (w < nwords && k < 4000) begin
      @(negedge clock);
      in_valid = !(bubbles && (k % 3 == 2));
      in_data  = in_valid ? BITWIDTH'(base + w) : '1;
      start    = (w == start_at) && !spulsed;
      if (start) spulsed = 1'b1;
      if (in_valid && in_ready !== 1'b1) chk_b("bp_write_cycle", wr_en, 1'b1);
      if (in_valid && in_ready === 1'b1) begin
        if (w == 0) first_cyc = cyc;
        w++;
      end else if (!in_valid && in_ready === 1'b1 && w > 0) begin
        idle++;
      end
      k++;
    end
    chk_i("stream_progress", w, nwords);
    if (nwords == NROWS*NCOLS) begin
      for (int i = 0; i < 64 && done !== 1'b1; i++) begin
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b0;
      end
      chk_b("done_set", done, 1'b1);
      chk_b("done_busy_low", busy, 1'b0);
      chk_i("done_latency", int'(cyc - first_cyc), NROWS*(NCOLS+1) + idle);
      chk_i("write_count", wa_q.size(), NROWS);
      for (int r = 0; r < NROWS; r++) begin
        if (r < wa_q.size()) begin
          chk_w($sformatf("wr_addr_%0d", r), ROW_W'(wa_q[r]), ROW_W'(r));
          chk_w($sformatf("wr_data_%0d", r), wd_q[r], exp_row(base, r));
        end
      end
      if (wd_q.size() > 5) begin
        rw = wd_q[5];
        chk_i("row5_col3", int'(rw[3*BITWIDTH +: BITWIDTH]), base + 83);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = '1;
    repeat (3) begin
      @(negedge clock);
      chk_b("rst_in_ready", in_ready, 1'b0);
      chk_b("rst_wr_en", wr_en, 1'b0);
      chk_w("rst_wr_addr", ROW_W'(wr_addr), '0);
      chk_w("rst_wr_data", wr_data, '0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
    end

    // start held through reset release is taken on the first edge.
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    chk_b("release_start_busy", busy, 1'b1);
    chk_b("release_start_ready", in_ready, 1'b1);
    start = 1'b0;

    load(0, 1'b0, -1, NROWS*NCOLS);

    pulse_start();
    load(0, 1'b1, -1, NROWS*NCOLS);

    pulse_start();
    load(0, 1'b0, 40, NROWS*NCOLS);

    // Reset lands after 7 words of row 3 have been taken.
    pulse_start();
    load(0, 1'b0, -1, 3*NCOLS + 7);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk_b("midrst_in_ready", in_ready, 1'b0);
    chk_b("midrst_wr_en", wr_en, 1'b0);
    chk_w("midrst_wr_addr", ROW_W'(wr_addr), '0);
    chk_w("midrst_wr_data", wr_data, '0);
    chk_b("midrst_busy", busy, 1'b0);
    chk_b("midrst_done", done, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    chk_b("post_rst_idle", in_ready, 1'b0);

    pulse_start();
    load(500, 1'b0, -1, NROWS*NCOLS);
    chk_w("ram_row3_fresh", ram[3], exp_row(500, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
